// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - state_t   : arbiter FSM state encoding
//   - PORT_CPU / PORT_DMA : requester port indices
//   - port_onehot() : converts a port index into a per-port strobe vector
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int NUM_PORTS = 2;

  // Strobe vector with only the bit of the given port set.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    logic [NUM_PORTS-1:0] vec;
    vec = '0;
    vec[port] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick.
// Ports:
//   req    in  2  request vector, bit i = port i
//   prio   in  1  port that wins when both request
//   winner out 1  selected port (only meaningful when any = 1)
//   any    out 1  at least one request present
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = prio;
    end else if (req[1]) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one 8-bit memory bus between port 0 (CPU) and port 1 (DMA/scanner).
// At most one access every two cycles: S_ISSUE drives the bus and pulses
// gnt for the winner, S_RESP pulses rvalid with the captured read data.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0/1, we0/1              request and write enable per port
//   addr0/1, wdata0/1          access address and write data per port
//   gnt0/1                     one-cycle grant pulse (access issued)
//   rvalid0/1, rdata0/1        one-cycle completion pulse and read data
//   mem_addr, mem_wdata, mem_we registered memory bus
//   mem_rdata                  combinational read data for mem_addr
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Port inputs gathered into vectors so they can be indexed by winner.
  logic [1:0]             req_vec;
  logic [1:0]             we_vec;
  logic [1:0][ADDR_W-1:0] addr_vec;
  logic [1:0][DATA_W-1:0] wdata_vec;

  assign req_vec   = {req1, req0};
  assign we_vec    = {we1, we0};
  assign addr_vec  = {addr1, addr0};
  assign wdata_vec = {wdata1, wdata0};

  state_t state_reg;
  state_t state_next;
  logic   grant;             // next cycle is S_ISSUE for a freshly arbitrated access
  logic   prio_reg;
  logic   owner_reg;         // port of the access currently in flight
  logic   winner;
  logic   any_req;

  logic [1:0]        gnt_reg;
  logic [1:0]        rvalid_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_we_reg;
  logic [1:0][DATA_W-1:0] rdata_bus;

  rr_pick2 u_pick (
    .req    (req_vec),
    .prio   (prio_reg),
    .winner (winner),
    .any    (any_req)
  );

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM next state. Requests are only sampled when leaving S_IDLE or
  // S_RESP, so a req still high at the end of S_RESP is a new access.
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          state_next = S_ISSUE;
          grant      = 1'b1;
        end
      end
      S_ISSUE: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        if (any_req) begin
          state_next = S_ISSUE;
          grant      = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Bus, grant, priority and response strobes. Everything is loaded on
  // the edge that enters S_ISSUE so outputs never depend on req
  // combinationally.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg      <= PORT_CPU;
      owner_reg     <= PORT_CPU;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
    end else begin
      if (grant) begin
        mem_addr_reg  <= addr_vec[winner];
        mem_wdata_reg <= wdata_vec[winner];
        owner_reg     <= winner;
        // Loser gets priority next time so neither port waits more
        // than one foreign access.
        prio_reg      <= ~winner;
      end
      // Write strobe only lives for the single S_ISSUE cycle.
      mem_we_reg <= grant & we_vec[winner];
      gnt_reg    <= grant ? port_onehot(winner) : 2'b00;
      rvalid_reg <= (state_reg == S_ISSUE) ? port_onehot(owner_reg) : 2'b00;
    end
  end

  // ------------------------------------------------------------------
  // Per-port read data registers. Only the port that owns the access
  // in S_ISSUE updates; a write returns zero as its acknowledge data.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;
      logic              is_owner;

      assign is_owner = (owner_reg == (gi == 1));

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (state_reg == S_ISSUE && is_owner) begin
          rdata_reg <= mem_we_reg ? '0 : mem_rdata;
        end
      end

      assign rdata_bus[gi] = rdata_reg;
    end
  endgenerate

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata0    = rdata_bus[0];
  assign rdata1    = rdata_bus[1];
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single 8-bit RAM/ROM bus of the CPU test system between two requesters: port 0 (CPU) and port 1 (DMA/display scanner). It grants at most one access per two cycles, using round-robin priority, and returns read data through a registered response. It sits between the requesters and the memory array, and replaces the direct CPU-to-memory wiring in the top level.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request, held until the matching gnt is seen
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: access is issued this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: access completed
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_we  out  1  memory write strobe (registered)
- mem_rdata  in  DATA_W  combinational memory read data for mem_addr

## Operation
- FSM states:
  - S_IDLE: no access in flight.
  - S_ISSUE: memory bus driven for the winner; gnt of the winner is high.
  - S_RESP: rvalid of the winner is high.
- Transitions:
  - S_IDLE → S_ISSUE when any req is high, otherwise stay in S_IDLE.
  - S_ISSUE → S_RESP unconditionally.
  - S_RESP → S_ISSUE when any req is high, otherwise → S_IDLE.
- Arbitration happens on entry to S_ISSUE. Only one req high: that port wins. Both high: the port named by prio wins.
- prio is a 1-bit pointer. After every grant it is set to the port that lost, i.e. the other port, so each port waits at most one foreign access.
- In S_ISSUE:
  - mem_addr / mem_wdata / mem_we are loaded from the winner's inputs.
  - mem_we = we of the winner.
  - mem_rdata is captured into the winner's rdata register at the end of the cycle.
- For a write, rdata is set to 0. rvalid still pulses and serves as the write acknowledge.
- The non-winning rdata register holds its previous value.
- Requester rule: drop req, or present a new access, no earlier than the cycle after gnt. Because the arbiter samples req only on entry to S_ISSUE, a req held high through S_RESP is treated as a new request.
- Changing addr/we/wdata while req is high and gnt has not yet been seen is legal; the values in force on the cycle before gnt are used.

## Timing
- Reset values:
  - state = S_IDLE, prio = 0
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = 0
- Latency from req rising in S_IDLE at cycle N:
  - gnt and mem_* at cycle N+1.
  - rvalid/rdata at cycle N+2.
- Throughput: one access per 2 cycles under continuous requests. Two back-to-back contending ports alternate 0,1,0,1,… provided prio = 0 at start.
- mem_we is high for exactly one cycle per write, and only in S_ISSUE.
- At most one of gnt0/gnt1 is high at a time; the same holds for rvalid0/rvalid1.
- Reset asserted mid-access:
  - In S_ISSUE: the write may already have occurred. The following rvalid is suppressed, and mem_we is 0 on the cycle after reset is sampled.
  - In S_RESP: rvalid is dropped the next cycle.
- All outputs are registered; there are no combinational paths from req to gnt.

## Structure
- Shared package `mem_arbiter_pkg`:
  - state encoding S_IDLE=2'd0, S_ISSUE=2'd1, S_RESP=2'd2
  - port indices PORT_CPU=1'b0, PORT_DMA=1'b1
- One combinational sub-module `rr_pick2`: inputs req[1:0] and prio; outputs winner and any. Tested stand-alone.
- Registered FSM, prio and datapath muxing in `mem_arbiter`.

## Test plan
- Single read, port 0: addr0=8'h81, mem holds 8'h3F → gnt0 at N+1, mem_addr=8'h81, mem_we=0, rvalid0 with rdata0=8'h3F at N+2, port 1 outputs quiet.
- Single write, port 1: addr1=8'h01, wdata1=8'hF0, we1=1 → mem_we pulses one cycle with mem_addr=8'h01, mem_wdata=8'hF0. A subsequent port 0 read of 8'h01 returns 8'hF0 in rdata0.
- Simultaneous req0/req1 held continuously after reset → grant order 0,1,0,1; gnt pulses every 2 cycles; never both gnt high.
- Port 1 requests continuously, port 0 raises req mid-stream → port 0 granted at the next S_ISSUE after port 1's current access (wait ≤ 3 cycles).
- Reset asserted during S_ISSUE of a write → no rvalid follows; all outputs equal reset values on the next cycle; state S_IDLE, prio 0.
- Idle: no req for 10 cycles → state stays S_IDLE, mem_we=0, no gnt/rvalid.
